button_debouncer: RTL and testbench
===================================

# button_debouncer

Pushbutton/switch conditioning stage that sits directly upstream of the lab's mod-5 counter. It synchronizes a raw asynchronous switch input and filters contact bounce with a qualification counter. It produces a clean debounced level and a one-clock rising-edge pulse, `db_tick`. `db_tick` drives the counter's `w` input, so each physical press advances the count exactly once.

## Interface
- `STABLE_CYCLES`, default 1_000_000. Number of consecutive synchronized clock cycles the input must hold a new value before it is accepted. Legal range is ≥ 2. Benches override it to 4.
- `CW`, default `$clog2(STABLE_CYCLES)`. Qualification counter width. Derived; not to be overridden.

Ports:
- `clk`  input  1  single system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset; clears all state immediately, independent of `clk`.
- `sw`  input  1  raw switch/button level; asynchronous to `clk`, may bounce.
- `db_level`  output  1  debounced level, registered.
- `db_tick`  output  1  one-cycle pulse on each accepted 0→1 transition, registered. Connects to the downstream counter's `w`.

## Operation
- **Synchronizer:** two flops, `sw` → `s1` → `s2`. `sw_s` = `s2`. The FSM only ever sees `sw_s`.
- **FSM:** four states, encoded 2 bits: ZERO, WAIT1, ONE, WAIT0.
- **Qualification counter:** `q[CW-1:0]`, load value `STABLE_CYCLES-1`, decrement by 1, never wraps.
- **ZERO** (`db_level` = 0):
  - `sw_s` = 1 → load `q`, go WAIT1.
  - Otherwise hold.
- **WAIT1** (`db_level` = 0):
  - `sw_s` = 0 → ZERO; the counter value is discarded.
  - `sw_s` = 1 and `q` = 0 → ONE.
  - `sw_s` = 1 and `q` ≠ 0 → decrement `q`.
- **ONE** (`db_level` = 1):
  - `sw_s` = 0 → load `q`, go WAIT0.
  - Otherwise hold.
- **WAIT0** (`db_level` = 1):
  - `sw_s` = 1 → ONE, with no `db_tick`.
  - `sw_s` = 0 and `q` = 0 → ZERO.
  - `sw_s` = 0 and `q` ≠ 0 → decrement `q`.
- **Outputs:**
  - `db_level` is high exactly when the state is ONE or WAIT0.
  - `db_tick` is high for exactly the one cycle in which the state register first holds ONE after WAIT1. It is a registered flag set on the WAIT1→ONE transition and cleared the next cycle.
  - A WAIT0→ONE return never raises `db_tick`.
- No falling-edge pulse is generated.

## Timing
- **Reset values:** `s1` = `s2` = 0, state ZERO, `q` = 0, `db_level` = 0, `db_tick` = 0. Reset acts asynchronously on assertion; release is synchronous to the next edge.
- **Press latency:** take `sw` rising and staying high, set up before edge E1.
  - `sw_s` = 1 after E2.
  - WAIT1 is entered at E3.
  - ONE is entered at E3+`STABLE_CYCLES`.
  - `db_level` and `db_tick` rise together after that edge; `db_tick` falls one edge later.
  - With `STABLE_CYCLES` = 4: outputs rise at E7 and `db_tick` is high during cycle E7–E8 only.
- **Release latency:** symmetric. `db_level` falls `STABLE_CYCLES`+3 edges after `sw` falls.
- **Bounce rejection:** any excursion of `sw_s` lasting fewer than `STABLE_CYCLES` cycles causes no change in `db_level` and no `db_tick`.
- **Held input:** `sw` held high indefinitely yields exactly one `db_tick`. There is no auto-repeat.
- **Reset mid-operation:** reset in WAIT1 or WAIT0 aborts qualification. After release with `sw` still high, the full sync plus `STABLE_CYCLES` qualification repeats and yields one tick. Reset asserted while `db_tick` = 1 clears it immediately.
- **Minimum spacing:** consecutive `db_tick` pulses are at least 2·`STABLE_CYCLES`+2 cycles apart.

## Test plan
All scenarios use `STABLE_CYCLES` = 4.

1. **Reset:** assert `reset` with `sw` = 1, including mid-WAIT1 → `db_level` = 0 and `db_tick` = 0 immediately. After release, the first `db_tick` appears at the 7th edge.
2. **Clean press:** `sw` 0→1, held 30 cycles → `db_level` rises at edge 7 and stays high. `db_tick` is high for exactly 1 cycle, with a total count of 1.
3. **Press bounce:** `sw` pattern 1,1,0,1,1,1,0,1 followed by 0 → `db_level` stays 0 and `db_tick` count = 0. Then hold 1 for 10 cycles → one tick.
4. **Release:** from ONE, `sw` 1→0 held → `db_level` falls 7 edges later and no `db_tick` occurs. Release bounce (0 for 2 cycles, then back to 1) → `db_level` stays 1 with no tick.
5. **Integration with the mod-5 counter:** 4 clean presses, each spaced 20 cycles, into `w` → `cout` = 1 after the 4th tick. A 5th press → `cout` = 0.

Source files
------------

// File: rtl/button_debouncer.sv
// Switch conditioning: two-flop synchronizer feeding a four-state
// qualification FSM. Emits a registered debounced level and a one-cycle
// pulse on each accepted press (0->1); releases produce no pulse.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CW            = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  // Counter is loaded on leaving a settled state and qualifies on reaching 0,
  // so a new level must hold STABLE_CYCLES synchronized cycles to be accepted.
  localparam logic [CW-1:0] LOAD = CW'(STABLE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          sw_s;
  state_t        state_q, state_d;
  logic [CW-1:0] q_q, q_d;
  logic          level_q, level_d;
  logic          tick_q, tick_d;

  assign sw_s = s2_q;

  // Two-flop synchronizer for the asynchronous switch input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
    end
  end

  // State, qualification counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ZERO;
      q_q     <= '0;
      level_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state, counter update and output decode.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    case (state_q)
      ZERO: begin
        if (sw_s) begin
          q_d     = LOAD;
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_d = ZERO;
        end else if (q_q == '0) begin
          state_d = ONE;
        end else begin
          q_d = q_q - CW'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          q_d     = LOAD;
          state_d = WAIT0;
        end
      end
      WAIT0: begin
        // Returning to ONE here is a rejected release glitch, not a new press.
        if (sw_s) begin
          state_d = ONE;
        end else if (q_q == '0) begin
          state_d = ZERO;
        end else begin
          q_d = q_q - CW'(1);
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
    level_d = (state_d == ONE) || (state_d == WAIT0);
    tick_d  = (state_q == WAIT1) && (state_d == ONE);
  end

  assign db_level = level_q;
  assign db_tick  = tick_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES = 4.
// Each driven cycle pushes its expected outputs to a scoreboard queue; the
// entry is popped and compared once the clock edge has produced the outputs.
module tb_button_debouncer;

  localparam int S   = 4;
  localparam int LAT = S + 3;   // edges from sw change to output change

  logic clk;
  logic reset;
  logic sw;
  logic db_level;
  logic db_tick;

  int errors = 0;
  int checks = 0;
  int tick_total = 0;
  int base;

  // Stand-in for the downstream lab mod-5 counter; w is driven by db_tick.
  logic [2:0] cnt5;
  logic       cout;

  typedef struct {
    string tag;
    int    idx;
    logic  lvl;
    logic  tick;
  } exp_t;

  exp_t sb[$];

  button_debouncer #(.STABLE_CYCLES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (db_tick) tick_total <= tick_total + 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt5 <= 3'd0;
    else if (db_tick) cnt5 <= (cnt5 == 3'd4) ? 3'd0 : cnt5 + 3'd1;
  end
  assign cout = (cnt5 == 3'd4);

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of sw, then compare the outputs after the edge.
  task automatic step(input logic s, input logic el, input logic et,
                      input string tag, input int idx);
    exp_t e;
    e.tag = tag; e.idx = idx; e.lvl = el; e.tick = et;
    sb.push_back(e);
    sw = s;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("step %s[%0d] sw=%0b level=%0b tick=%0b", e.tag, e.idx, s, db_level, db_tick);
    chk($sformatf("%s[%0d].level", e.tag, e.idx), db_level, e.lvl);
    chk($sformatf("%s[%0d].tick", e.tag, e.idx), db_tick, e.tick);
  endtask

  // From settled ZERO: both outputs rise on edge LAT, tick lasts one cycle.
  task automatic press_run(input int n, input string tag);
    for (int i = 1; i <= n; i++) step(1'b1, i >= LAT, i == LAT, tag, i);
  endtask

  // From settled ONE: level falls on edge LAT, never a tick.
  task automatic release_run(input int n, input string tag);
    for (int i = 1; i <= n; i++) step(1'b0, i < LAT, 1'b0, tag, i);
  endtask

  logic [7:0] pat;

  initial begin
    reset = 1'b1;
    sw    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.level", db_level, 1'b0);
    chk("reset.tick", db_tick, 1'b0);
    #2 reset = 1'b0;

    // Abort mid-WAIT1: outputs must read 0 right after reset assertion.
    press_run(4, "rst_wait1");
    reset = 1'b1;
    #1;
    chk("rst_in_wait1.level", db_level, 1'b0);
    chk("rst_in_wait1.tick", db_tick, 1'b0);
    #2 reset = 1'b0;

    // Full qualification repeats; then reset while the tick is high.
    press_run(LAT, "rst_first_tick");
    reset = 1'b1;
    #1;
    chk("rst_clear_tick.level", db_level, 1'b0);
    chk("rst_clear_tick.tick", db_tick, 1'b0);
    #2 reset = 1'b0;
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 1'b0, "idle", i);

    // Clean press held 30 cycles.
    base = tick_total;
    press_run(30, "clean");
    chk_int("clean.tick_count", tick_total - base, 1);

    // Clean release.
    base = tick_total;
    release_run(10, "release");
    chk_int("release.tick_count", tick_total - base, 0);

    // Press bounce pattern 1,1,0,1,1,1,0,1 then 0: no qualification.
    base = tick_total;
    pat = 8'b11011101;
    for (int i = 7; i >= 0; i--) step(pat[i], 1'b0, 1'b0, "bounce", 7 - i);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 1'b0, "bounce_tail", i);
    chk_int("bounce.tick_count", tick_total - base, 0);
    press_run(10, "bounce_hold");
    chk_int("bounce_hold.tick_count", tick_total - base, 1);

    // Release bounce: two low cycles then high again keeps ONE, no tick.
    base = tick_total;
    step(1'b0, 1'b1, 1'b0, "rel_bounce", 0);
    step(1'b0, 1'b1, 1'b0, "rel_bounce", 1);
    for (int i = 2; i < 10; i++) step(1'b1, 1'b1, 1'b0, "rel_bounce", i);
    chk_int("rel_bounce.tick_count", tick_total - base, 0);
    release_run(10, "rel_settle");

    // Integration with the mod-5 counter.
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 1; i <= 2; i++) step(1'b0, 1'b0, 1'b0, "int_idle", i);
    base = tick_total;
    for (int p = 1; p <= 4; p++) begin
      press_run(10, $sformatf("int_press%0d", p));
      release_run(10, $sformatf("int_release%0d", p));
      if (p == 3) chk("int.cout_after3", cout, 1'b0);
    end
    chk("int.cout_after4", cout, 1'b1);
    press_run(10, "int_press5");
    release_run(10, "int_release5");
    chk("int.cout_after5", cout, 1'b0);
    chk_int("int.tick_count", tick_total - base, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
